// File: rtl/sail_mem_pkg.sv
//------------------------------------------------------------------------------
// sail_mem_pkg : shared types and default constants for the sail-core memory path
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package sail_mem_pkg;

    typedef enum logic [1:0] {
        PWR_ACTIVE = 2'd0,
        PWR_LIGHT  = 2'd1,
        PWR_DEEP   = 2'd2,
        PWR_WAKE   = 2'd3
    } pwr_state_t;

    localparam int DEF_LS_IDLE = 16;
    localparam int DEF_DS_IDLE = 1024;
    localparam int DEF_LS_WAKE = 1;
    localparam int DEF_DS_WAKE = 32;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    // One spare bit above the largest terminal count keeps saturation headroom.
    function automatic int cnt_width(input int ls_idle, input int ds_idle, input int ds_wake);
        int m;
        m = ls_idle;
        if (ds_idle > m) m = ds_idle;
        if (ds_wake > m) m = ds_wake;
        return $clog2(m) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/spram_pwr_ctrl_if.sv
//------------------------------------------------------------------------------
// spram_pwr_ctrl_if : core-side single-word req/ready access bus
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface spram_pwr_ctrl_if;
    import sail_mem_pkg::*;

    logic              req;
    logic              req_we;
    logic [BE_W-1:0]   req_be;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              ready;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, req_we, req_be, req_addr, req_wdata,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  req, req_we, req_be, req_addr, req_wdata,
        output ready, rvalid, rdata
    );

endinterface

`default_nettype wire

// File: rtl/spram_pwr_ctrl.sv
//------------------------------------------------------------------------------
// spram_pwr_ctrl : SPRAM access gate with idle-driven light/deep sleep control
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module spram_pwr_ctrl
    import sail_mem_pkg::*;
#(
    parameter int LS_IDLE = DEF_LS_IDLE,
    parameter int DS_IDLE = DEF_DS_IDLE,
    parameter int LS_WAKE = DEF_LS_WAKE,
    parameter int DS_WAKE = DEF_DS_WAKE
) (
    input  wire logic              clk,
    input  wire logic              rst,
    spram_pwr_ctrl_if.slave        core,
    input  wire logic              sleep_req,
    output logic [1:0]             pwr_state,
    output logic                   mem_sel,
    output logic                   mem_we,
    output logic [BE_W-1:0]        mem_be,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_din,
    input  wire logic [DATA_W-1:0] mem_dout,
    output logic                   mem_ls_req,
    output logic                   mem_ds_req
);

    localparam int c_cnt_w = cnt_width(LS_IDLE, DS_IDLE, DS_WAKE);

    localparam logic [c_cnt_w-1:0] c_zero    = '0;
    localparam logic [c_cnt_w-1:0] c_one     = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = '1;
    localparam logic [c_cnt_w-1:0] c_ls_last = c_cnt_w'(LS_IDLE - 1);
    localparam logic [c_cnt_w-1:0] c_ds_last = c_cnt_w'(DS_IDLE - 1);
    localparam logic [c_cnt_w-1:0] c_ls_wake = c_cnt_w'(LS_WAKE);
    localparam logic [c_cnt_w-1:0] c_ds_wake = c_cnt_w'(DS_WAKE);

    pwr_state_t           r_state;
    pwr_state_t           w_state_nxt;
    logic [c_cnt_w-1:0]   r_idle_cnt;
    logic [c_cnt_w-1:0]   w_idle_nxt;
    logic [c_cnt_w-1:0]   r_wake_cnt;
    logic [c_cnt_w-1:0]   w_wake_nxt;
    logic                 r_rvalid;
    logic                 w_accept;

    // ready is a pure decode of registered state, so there is no req->ready path.
    assign core.ready = (r_state == PWR_ACTIVE);
    assign w_accept   = core.req && core.ready;

    assign mem_sel    = w_accept;
    assign mem_we     = w_accept && core.req_we;
    assign mem_be     = core.req_be;
    assign mem_addr   = core.req_addr;
    assign mem_din    = core.req_wdata;

    // Pins decode the asynchronously reset state so they drop the moment rst rises.
    assign mem_ls_req = (r_state == PWR_LIGHT);
    assign mem_ds_req = (r_state == PWR_DEEP);
    assign pwr_state  = r_state;

    assign core.rvalid = r_rvalid;
    assign core.rdata  = mem_dout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= PWR_ACTIVE;
            r_idle_cnt <= '0;
            r_wake_cnt <= '0;
            r_rvalid   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idle_cnt <= w_idle_nxt;
            r_wake_cnt <= w_wake_nxt;
            r_rvalid   <= w_accept && !core.req_we;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idle_nxt  = r_idle_cnt;
        w_wake_nxt  = r_wake_cnt;
        unique case (r_state)
            PWR_ACTIVE: begin
                // A pending request always beats both sleep triggers.
                if (core.req) begin
                    w_idle_nxt = c_zero;
                end else if (sleep_req) begin
                    w_state_nxt = PWR_DEEP;
                    w_idle_nxt  = c_zero;
                end else if (r_idle_cnt == c_ls_last) begin
                    w_state_nxt = PWR_LIGHT;
                    w_idle_nxt  = c_zero;
                end else if (r_idle_cnt != c_cnt_max) begin
                    w_idle_nxt = r_idle_cnt + c_one;
                end
            end
            PWR_LIGHT: begin
                if (core.req) begin
                    w_state_nxt = PWR_WAKE;
                    w_idle_nxt  = c_zero;
                    w_wake_nxt  = c_ls_wake;
                end else if (sleep_req || (r_idle_cnt == c_ds_last)) begin
                    w_state_nxt = PWR_DEEP;
                    w_idle_nxt  = c_zero;
                end else if (r_idle_cnt != c_cnt_max) begin
                    w_idle_nxt = r_idle_cnt + c_one;
                end
            end
            PWR_DEEP: begin
                if (core.req) begin
                    w_state_nxt = PWR_WAKE;
                    w_idle_nxt  = c_zero;
                    w_wake_nxt  = c_ds_wake;
                end
            end
            PWR_WAKE: begin
                if (r_wake_cnt <= c_one) begin
                    w_state_nxt = PWR_ACTIVE;
                    w_idle_nxt  = c_zero;
                    w_wake_nxt  = c_zero;
                end else begin
                    w_wake_nxt = r_wake_cnt - c_one;
                end
            end
            default: begin
                w_state_nxt = PWR_ACTIVE;
                w_idle_nxt  = c_zero;
                w_wake_nxt  = c_zero;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_spram_pwr_ctrl.sv
//------------------------------------------------------------------------------
// tb_spram_pwr_ctrl : directed vector table plus multi-cycle power-state sequences
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_spram_pwr_ctrl;
    import sail_mem_pkg::*;

    logic        clk;
    logic        rst;
    logic        sleep_req;
    logic [1:0]  pwr_state;
    logic        mem_sel;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [15:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic        mem_ls_req;
    logic        mem_ds_req;

    int n_checks = 0;
    int n_fail   = 0;

    spram_pwr_ctrl_if core_if ();

    spram_pwr_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .core       (core_if),
        .sleep_req  (sleep_req),
        .pwr_state  (pwr_state),
        .mem_sel    (mem_sel),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout),
        .mem_ls_req (mem_ls_req),
        .mem_ds_req (mem_ds_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SPRAM behavioural model, read latency 1, cleared while rst is high.
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem_dout <= 32'h0;
        end else if (mem_sel) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) mem[mem_addr[7:0]][8*b +: 8] <= mem_din[8*b +: 8];
            end else begin
                mem_dout <= mem[mem_addr[7:0]];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic we, input logic [3:0] be,
                         input logic [15:0] a, input logic [31:0] d);
        core_if.req       = r;
        core_if.req_we    = we;
        core_if.req_be    = be;
        core_if.req_addr  = a;
        core_if.req_wdata = d;
    endtask

    // Entered #1 after a posedge with req already driven; returns #4 into the accept cycle.
    task automatic wait_accept(input int bound, output int n, output logic pins_ok);
        n = 0;
        pins_ok = 1'b1;
        #3;
        while (!core_if.ready && n < bound) begin
            if (n >= 1 && (mem_ls_req || mem_ds_req)) pins_ok = 1'b0;
            @(posedge clk);
            #1;
            n++;
            #3;
        end
    endtask

    typedef struct {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic        sleep;
        logic        exp_sel;
        logic        exp_we;
        logic        exp_rvalid;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_state;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        logic ok;

        vecs[0] = '{1'b1, 1'b1, 4'hF, 16'h0010, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        2'd0};
        vecs[1] = '{1'b1, 1'b0, 4'hF, 16'h0010, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 2'd0};
        vecs[2] = '{1'b1, 1'b1, 4'h5, 16'h0020, 32'h12345678, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        2'd0};
        vecs[3] = '{1'b1, 1'b0, 4'hF, 16'h0020, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 32'h00340078, 2'd0};
        vecs[4] = '{1'b0, 1'b0, 4'h0, 16'h0000, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        2'd0};
        vecs[5] = '{1'b1, 1'b1, 4'hF, 16'h0030, 32'hCAFEF00D, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        2'd0};
        vecs[6] = '{1'b1, 1'b0, 4'hF, 16'h0030, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 32'hCAFEF00D, 2'd0};
        vecs[7] = '{1'b0, 1'b0, 4'h0, 16'h0000, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        2'd2};

        rst = 1'b1;
        sleep_req = 1'b0;
        drive(1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready",  core_if.ready,  1);
        check("rst_rvalid", core_if.rvalid, 0);
        check("rst_sel",    mem_sel,        0);
        check("rst_we",     mem_we,         0);
        check("rst_ls",     mem_ls_req,     0);
        check("rst_ds",     mem_ds_req,     0);
        check("rst_state",  pwr_state,      0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].req, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata);
            sleep_req = vecs[i].sleep;
            #3;
            check($sformatf("v%0d_ready", i), core_if.ready, 1);
            check($sformatf("v%0d_sel", i),   mem_sel, vecs[i].exp_sel);
            check($sformatf("v%0d_we", i),    mem_we,  vecs[i].exp_we);
            if (vecs[i].exp_sel) begin
                check($sformatf("v%0d_addr", i), mem_addr, vecs[i].addr);
                check($sformatf("v%0d_be", i),   mem_be,   vecs[i].be);
                check($sformatf("v%0d_din", i),  mem_din,  vecs[i].wdata);
            end
            @(posedge clk);
            #1;
            check($sformatf("v%0d_rvalid", i), core_if.rvalid, vecs[i].exp_rvalid);
            if (vecs[i].exp_rvalid)
                check($sformatf("v%0d_rdata", i), core_if.rdata, vecs[i].exp_rdata);
            check($sformatf("v%0d_state", i), pwr_state, vecs[i].exp_state);
        end

        // Sleep-entered DEEP; wake with sleep_req still high.
        check("deep_ds",    mem_ds_req,    1);
        check("deep_ls",    mem_ls_req,    0);
        check("deep_ready", core_if.ready, 0);
        drive(1'b1, 1'b0, 4'hF, 16'h0030, 32'h0);
        wait_accept(200, n, ok);
        check("ds_wake_lat",  n,  33);
        check("ds_wake_pins", ok, 1);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
        sleep_req = 1'b0;
        check("ds_rd_rvalid", core_if.rvalid, 1);
        check("ds_rd_rdata",  core_if.rdata,  32'hCAFEF00D);

        // Light-sleep entry after 16 idle cycles.
        repeat (15) @(posedge clk);
        #1;
        check("ls_pre_state", pwr_state,  0);
        check("ls_pre_pin",   mem_ls_req, 0);
        @(posedge clk);
        #1;
        check("ls_state", pwr_state,     1);
        check("ls_pin",   mem_ls_req,    1);
        check("ls_ready", core_if.ready, 0);

        // Access from LIGHT.
        drive(1'b1, 1'b1, 4'hF, 16'h0040, 32'hA5A5A5A5);
        wait_accept(50, n, ok);
        check("ls_wake_lat",  n,  2);
        check("ls_wake_pins", ok, 1);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 4'h0, 16'h0, 32'h0);

        // Request coincident with the light-sleep timeout cycle.
        repeat (15) @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 4'hF, 16'h0040, 32'h0);
        #3;
        check("tmo_ready", core_if.ready, 1);
        check("tmo_sel",   mem_sel,       1);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
        check("tmo_state",  pwr_state,      0);
        check("tmo_ls",     mem_ls_req,     0);
        check("tmo_rvalid", core_if.rvalid, 1);
        check("tmo_rdata",  core_if.rdata,  32'hA5A5A5A5);

        // Idle all the way into DEEP: 16 + 1024 cycles.
        repeat (1039) @(posedge clk);
        #1;
        check("idle_light_state", pwr_state,  1);
        check("idle_light_ls",    mem_ls_req, 1);
        @(posedge clk);
        #1;
        check("idle_deep_state", pwr_state,  2);
        check("idle_deep_ds",    mem_ds_req, 1);
        check("idle_deep_ls",    mem_ls_req, 0);
        drive(1'b1, 1'b0, 4'hF, 16'h0010, 32'h0);
        wait_accept(200, n, ok);
        check("idle_ds_lat", n, 33);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
        check("idle_ds_rvalid", core_if.rvalid, 1);
        check("idle_ds_rdata",  core_if.rdata,  32'hDEADBEEF);

        // Reset asserted in the middle of a wake from DEEP.
        sleep_req = 1'b1;
        @(posedge clk);
        #1;
        sleep_req = 1'b0;
        check("mw_deep", pwr_state, 2);
        drive(1'b1, 1'b0, 4'hF, 16'h0020, 32'h0);
        repeat (5) @(posedge clk);
        #1;
        check("mw_wake_state", pwr_state,     3);
        check("mw_wake_ready", core_if.ready, 0);
        drive(1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
        rst = 1'b1;
        #1;
        check("mw_rst_state",  pwr_state,      0);
        check("mw_rst_ready",  core_if.ready,  1);
        check("mw_rst_sel",    mem_sel,        0);
        check("mw_rst_rvalid", core_if.rvalid, 0);
        check("mw_rst_ls",     mem_ls_req,     0);
        check("mw_rst_ds",     mem_ds_req,     0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b1, 1'b1, 4'hF, 16'h0050, 32'h0BADF00D);
        #3;
        check("post_rst_ready", core_if.ready, 1);
        check("post_rst_sel",   mem_sel,       1);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 4'hF, 16'h0050, 32'h0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
        check("post_rst_rvalid", core_if.rvalid, 1);
        check("post_rst_rdata",  core_if.rdata,  32'h0BADF00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
